// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - pixel/sync bus between the raster generator and the score overlay
interface score_keeper_if;
  logic       i_hSync;
  logic       i_vSync;
  logic [9:0] i_display_x_pos;
  logic [9:0] i_display_y_pos;
  logic [2:0] o_red;
  logic [2:0] o_green;
  logic [2:0] o_blue;
  logic       o_hSync;
  logic       o_vSync;

  modport master (
    output i_hSync, i_vSync, i_display_x_pos, i_display_y_pos,
    input  o_red, o_green, o_blue, o_hSync, o_vSync
  );

  modport slave (
    input  i_hSync, i_vSync, i_display_x_pos, i_display_y_pos,
    output o_red, o_green, o_blue, o_hSync, o_vSync
  );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-player score FSM with seven-segment score overlay
module score_keeper #(
  parameter int WIN_SCORE   = 9,
  parameter int RESTART_KEY = 114,
  parameter int P1_X        = 256,
  parameter int P2_X        = 360,
  parameter int DIGIT_Y     = 20,
  parameter int SEG_LEN     = 16,
  parameter int SEG_THK     = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_p1_scored,
  input  logic             i_p2_scored,
  input  logic [7:0]       i_key_byte,
  score_keeper_if.slave    vid,
  output logic [3:0]       o_p1_score,
  output logic [3:0]       o_p2_score,
  output logic             o_game_over
);

  typedef enum logic [1:0] {PLAY, P1_WON, P2_WON} state_t;

  localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);
  localparam logic [7:0]  KEY8    = 8'(RESTART_KEY);
  localparam logic [10:0] SL      = 11'(SEG_LEN);
  localparam logic [10:0] ST      = 11'(SEG_THK);
  localparam logic [10:0] BOX_W   = 11'(SEG_LEN + 2 * SEG_THK);
  localparam logic [10:0] BOX_H   = 11'(2 * SEG_LEN + 3 * SEG_THK);
  localparam logic [10:0] P1X     = 11'(P1_X);
  localparam logic [10:0] P2X     = 11'(P2_X);
  localparam logic [10:0] DYL     = 11'(DIGIT_Y);

  // Segment mask order: {a, b, c, d, e, f, g}
  function automatic logic [6:0] digit_mask(input logic [3:0] d);
    case (d)
      4'd0:    digit_mask = 7'b1111110;
      4'd1:    digit_mask = 7'b0110000;
      4'd2:    digit_mask = 7'b1101101;
      4'd3:    digit_mask = 7'b1111001;
      4'd4:    digit_mask = 7'b0110011;
      4'd5:    digit_mask = 7'b1011011;
      4'd6:    digit_mask = 7'b1011111;
      4'd7:    digit_mask = 7'b1110000;
      4'd8:    digit_mask = 7'b1111111;
      4'd9:    digit_mask = 7'b1111011;
      default: digit_mask = 7'b0000000;
    endcase
  endfunction

  // dx/dy are box-relative and assumed already inside the glyph box
  function automatic logic seg_lit(input logic [10:0] dx, input logic [10:0] dy,
                                   input logic [6:0] m);
    logic top, bot, left, right;
    top   = dy < (SL + 2 * ST);
    bot   = dy >= (SL + ST);
    left  = dx < ST;
    right = dx >= (BOX_W - ST);
    seg_lit = (m[6] && dy < ST)
           || (m[0] && dy >= (SL + ST) && dy < (SL + 2 * ST))
           || (m[3] && dy >= (2 * SL + 2 * ST))
           || (m[1] && left && top)
           || (m[5] && right && top)
           || (m[2] && left && bot)
           || (m[4] && right && bot);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic        game_over_q, game_over_d;
  logic        p1_meta_q, p1_meta_d, p1_sync_q, p1_sync_d, p1_prev_q, p1_prev_d;
  logic        p2_meta_q, p2_meta_d, p2_sync_q, p2_sync_d, p2_prev_q, p2_prev_d;
  logic        p1_armed_q, p1_armed_d, p2_armed_q, p2_armed_d;
  logic [1:0]  fill_q, fill_d;
  logic [7:0]  key_prev_q, key_prev_d;
  logic [2:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;

  logic        p1_ev, p2_ev, restart;
  logic [10:0] x11, y11, dx1, dx2, dy;
  logic        visible, in_rows, in_box1, in_box2, p1_px, p2_px, green_only;

  // A score line that was high across reset must be seen low once the
  // synchroniser has refilled before its next rising edge may count.
  always_comb begin
    p1_meta_d  = i_p1_scored;
    p1_sync_d  = p1_meta_q;
    p1_prev_d  = p1_sync_q;
    p2_meta_d  = i_p2_scored;
    p2_sync_d  = p2_meta_q;
    p2_prev_d  = p2_sync_q;
    fill_d     = {fill_q[0], 1'b1};
    p1_armed_d = p1_armed_q | (fill_q[1] & ~p1_sync_q);
    p2_armed_d = p2_armed_q | (fill_q[1] & ~p2_sync_q);
    key_prev_d = i_key_byte;
    p1_ev      = p1_armed_q & p1_sync_q & ~p1_prev_q;
    p2_ev      = p2_armed_q & p2_sync_q & ~p2_prev_q;
    restart    = (i_key_byte == KEY8) && (key_prev_q != KEY8);
  end

  always_comb begin
    state_d    = state_q;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    if (restart) begin
      state_d    = PLAY;
      p1_score_d = 4'd0;
      p2_score_d = 4'd0;
    end else begin
      case (state_q)
        PLAY: begin
          if (p1_ev && !p2_ev) begin
            p1_score_d = p1_score_q + 4'd1;
            if (p1_score_d == WIN4) state_d = P1_WON;
          end else if (p2_ev && !p1_ev) begin
            p2_score_d = p2_score_q + 4'd1;
            if (p2_score_d == WIN4) state_d = P2_WON;
          end
        end
        P1_WON, P2_WON: ;
        default: state_d = PLAY;
      endcase
    end
    game_over_d = (state_d != PLAY);
  end

  always_comb begin
    x11        = {1'b0, vid.i_display_x_pos};
    y11        = {1'b0, vid.i_display_y_pos};
    dx1        = x11 - P1X;
    dx2        = x11 - P2X;
    dy         = y11 - DYL;
    visible    = (vid.i_display_x_pos < 10'd640) && (vid.i_display_y_pos < 10'd480);
    in_rows    = (y11 >= DYL) && (y11 < DYL + BOX_H);
    in_box1    = in_rows && (x11 >= P1X) && (x11 < P1X + BOX_W);
    in_box2    = in_rows && (x11 >= P2X) && (x11 < P2X + BOX_W);
    p1_px      = visible && in_box1 && seg_lit(dx1, dy, digit_mask(p1_score_q));
    p2_px      = visible && in_box2 && seg_lit(dx2, dy, digit_mask(p2_score_q));
    green_only = (p1_px && state_q == P1_WON) || (p2_px && state_q == P2_WON);
    red_d      = 3'b000;
    green_d    = 3'b000;
    blue_d     = 3'b000;
    if (green_only) begin
      green_d = 3'b111;
    end else if (p1_px || p2_px) begin
      red_d   = 3'b111;
      green_d = 3'b111;
      blue_d  = 3'b111;
    end
    hsync_d = vid.i_hSync;
    vsync_d = vid.i_vSync;
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q     <= PLAY;
      p1_score_q  <= 4'd0;
      p2_score_q  <= 4'd0;
      game_over_q <= 1'b0;
      p1_meta_q   <= 1'b0;
      p1_sync_q   <= 1'b0;
      p1_prev_q   <= 1'b0;
      p2_meta_q   <= 1'b0;
      p2_sync_q   <= 1'b0;
      p2_prev_q   <= 1'b0;
      p1_armed_q  <= 1'b0;
      p2_armed_q  <= 1'b0;
      fill_q      <= 2'b00;
      key_prev_q  <= 8'd0;
      red_q       <= 3'b000;
      green_q     <= 3'b000;
      blue_q      <= 3'b000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      game_over_q <= game_over_d;
      p1_meta_q   <= p1_meta_d;
      p1_sync_q   <= p1_sync_d;
      p1_prev_q   <= p1_prev_d;
      p2_meta_q   <= p2_meta_d;
      p2_sync_q   <= p2_sync_d;
      p2_prev_q   <= p2_prev_d;
      p1_armed_q  <= p1_armed_d;
      p2_armed_q  <= p2_armed_d;
      fill_q      <= fill_d;
      key_prev_q  <= key_prev_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign o_p1_score  = p1_score_q;
  assign o_p2_score  = p2_score_q;
  assign o_game_over = game_over_q;
  assign vid.o_red   = red_q;
  assign vid.o_green = green_q;
  assign vid.o_blue  = blue_q;
  assign vid.o_hSync = hsync_q;
  assign vid.o_vSync = vsync_q;

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_SCORE, default 9: score that ends the game, legal range 1..9.
REQ-002 Parameter RESTART_KEY, default 114 ('r'): UART key byte that restarts the game.
REQ-003 Parameter P1_X, default 256: left edge of the player-1 digit, in pixels.
REQ-004 Parameter P2_X, default 360: left edge of the player-2 digit, in pixels.
REQ-005 Parameter DIGIT_Y, default 20: top edge of both digits, in pixels.
REQ-006 Parameter SEG_LEN, default 16: segment length in pixels.
REQ-007 Parameter SEG_THK, default 4: segment thickness in pixels.
REQ-008 i_CLK  input  1  pixel clock; the only clock in the block.
REQ-009 i_RST_N  input  1  reset; synchronous and active-low.
REQ-010 i_p1_scored  input  1  player-1 score level from ball logic (slow-clock domain, held at least 1 slow tick).
REQ-011 i_p2_scored  input  1  player-2 score level; same behaviour as i_p1_scored.
REQ-012 i_key_byte  input  8  last received UART byte; holds its value until the next byte arrives.
REQ-013 i_hSync, i_vSync  input  1 each  sync from the sync/porch generator.
REQ-014 i_display_x_pos, i_display_y_pos  input  10 each  current pixel coordinates.
REQ-015 o_red, o_green, o_blue  output  3 each  digit overlay colour, to be OR-combined at top level.
REQ-016 o_hSync, o_vSync  output  1 each  sync inputs delayed to align with the colour outputs.
REQ-017 o_p1_score, o_p2_score  output  4 each  current scores, binary 0..9.
REQ-018 o_game_over  output  1  high while a winner is declared.

Function
REQ-019 The block SHALL pass i_p1_scored and i_p2_scored through 2-flop synchronisers, then detect rising edges; each edge is one score event.
- A level held for any number of cycles counts once.
REQ-020 The block SHALL detect a restart event when i_key_byte == RESTART_KEY and the registered previous i_key_byte != RESTART_KEY.
REQ-021 The FSM SHALL have three states: PLAY, P1_WON and P2_WON; reset state is PLAY.
REQ-022 In PLAY, a p1 event alone SHALL increment p1 score; a p2 event alone SHALL increment p2 score.
REQ-023 In PLAY, p1 and p2 events in the same cycle SHALL both be discarded: no change to either score.
REQ-024 When an increment makes a score equal WIN_SCORE, the FSM SHALL go to P1_WON or P2_WON on the same clock edge that registers the new score.
REQ-025 In P1_WON and P2_WON, score events SHALL be ignored and o_game_over SHALL be 1.
REQ-026 A restart event in any state SHALL clear both scores and enter PLAY on the next edge.
- If a restart event and a score event occur in the same cycle, restart wins.
REQ-027 Scores SHALL never exceed WIN_SCORE; there is no wrap-around.
REQ-028 Each digit SHALL be a seven-segment glyph in a box SEG_LEN+2*SEG_THK wide and 2*SEG_LEN+3*SEG_THK tall.
- Horizontal segments a, g, d span the full box width, at rows 0, SEG_LEN+SEG_THK and 2*SEG_LEN+2*SEG_THK.
- Vertical segments f, b, e, c are SEG_THK wide and SEG_LEN+2*SEG_THK tall, at the box's left and right edges, upper and lower halves.
REQ-029 Segment decode SHALL use standard patterns for digits 0-9.
REQ-030 A pixel inside a lit segment SHALL produce colour 3'b111 on all three channels.
- Exception: in P1_WON or P2_WON, the winner's digit SHALL be green only (o_green=3'b111, o_red=o_blue=0).
- Every other pixel produces 0.
REQ-031 Pixels with x >= 640 or y >= 480 SHALL produce 0 on all colour outputs.
REQ-032 Colour outputs and o_hSync/o_vSync SHALL be registered with exactly 1 cycle latency from the pixel and sync inputs.
REQ-033 o_p1_score, o_p2_score and o_game_over SHALL be driven directly from state registers, with no extra latency.

Reset
REQ-034 While i_RST_N=0 at a rising edge of i_CLK, the block SHALL set both scores to 0, the state to PLAY, and o_game_over to 0.
REQ-035 At the same time it SHALL clear o_red, o_green and o_blue to 0, set o_hSync and o_vSync to 1, and clear the synchroniser and edge-detect flops and the previous-key register.
REQ-036 A reset asserted mid-game SHALL discard any in-flight score edge.
- A score input that is still high at reset release SHALL NOT be counted until it falls and rises again.

Verification
REQ-037 Pulse i_p1_scored high for 1000 cycles, 3 times -> o_p1_score=3, o_p2_score=0, o_game_over=0.
REQ-038 Raise i_p1_scored and i_p2_scored on the same cycle -> both scores unchanged.
REQ-039 With WIN_SCORE=9, give p2 nine events -> o_p2_score=9 and o_game_over=1; a tenth p2 event -> still 9; p2 digit pixels green-only.
REQ-040 In P2_WON, change i_key_byte 0->114 -> the next cycles show scores 0/0 and o_game_over=0; holding 114 causes no second restart.
REQ-041 With p1 score=8 (p1 glyph: all segments lit), sweep the raster -> the 7 lit rectangles match the geometry; colour and sync appear 1 cycle after inputs; no colour at x >= 640.
REQ-042 Assert i_RST_N=0 with p1 score=5 while i_p1_scored is high, then release -> scores 0/0, no increment until i_p1_scored toggles low then high.
